// File: rtl/pattern_source_gen.sv
// pattern_source_gen: known-value test-pattern source on a valid/ready link.
// After reset it holds off for HOLD_CYCLES, then streams CONST, COUNT,
// Galois LFSR or walking-one words; mode_load switches mode and restarts.
module pattern_source_gen #(
  parameter int               WIDTH       = 24,
  parameter logic [WIDTH-1:0] CONST_VAL   = WIDTH'(24'hC0FFEE),
  parameter logic [WIDTH-1:0] SEED        = WIDTH'(24'h000001),
  parameter logic [WIDTH-1:0] LFSR_TAPS   = WIDTH'(24'hE10000),
  parameter int               HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode_in,
  input  logic             mode_load,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       mode_q,
  output logic             holding
);

  localparam int CW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  localparam logic [1:0] M_CONST = 2'd0;
  localparam logic [1:0] M_COUNT = 2'd1;
  localparam logic [1:0] M_LFSR  = 2'd2;
  localparam logic [1:0] M_WALK  = 2'd3;

  typedef enum logic {HOLD, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A zero seed would lock the LFSR at zero, so it is replaced by 1.
  localparam logic [WIDTH-1:0] LFSR_INIT = (SEED == '0) ? WIDTH'(1) : SEED;

  function automatic logic [WIDTH-1:0] first_val(input logic [1:0] m);
    logic [WIDTH-1:0] v;
    v = '0;
    case (m)
      M_CONST: v = CONST_VAL;
      M_COUNT: v = '0;
      M_LFSR:  v = LFSR_INIT;
      M_WALK:  v = WIDTH'(1);
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] next_val(input logic [1:0] m,
                                                input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] v;
    v = r;
    case (m)
      M_CONST: v = CONST_VAL;
      M_COUNT: v = r + WIDTH'(1);
      M_LFSR:  v = (r >> 1) ^ (r[0] ? LFSR_TAPS : '0);
      M_WALK:  v = {r[WIDTH-2:0], r[WIDTH-1]};
      default: v = r;
    endcase
    return v;
  endfunction

  // State and hold-off counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      cnt_q   <= CW'(HOLD_CYCLES);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: leave HOLD on the edge the counter would reach zero
  // (immediately when HOLD_CYCLES is 0).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      HOLD: begin
        if (cnt_q <= CW'(1)) state_d = RUN;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      RUN:     state_d = RUN;
      default: state_d = HOLD;
    endcase
  end

  // Output word, valid and mode registers; a load beats a same-cycle transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      out_valid <= 1'b0;
      mode_q    <= M_CONST;
      holding   <= 1'b1;
    end else begin
      holding <= (state_d == HOLD);
      if (mode_load) mode_q <= mode_in;
      if (state_q == HOLD) begin
        if (state_d == RUN) begin
          result    <= first_val(mode_load ? mode_in : mode_q);
          out_valid <= en;
        end
      end else begin
        out_valid <= en;
        if (mode_load)                   result <= first_val(mode_in);
        else if (out_valid && out_ready) result <= next_val(mode_q, result);
      end
    end
  end

endmodule

// File: tb/tb_pattern_source_gen.sv
// Directed bench for pattern_source_gen: hold-off, all four modes,
// backpressure, load/transfer collision, enable freeze, mid-run reset.
// A WIDTH=4 copy checks counter wrap; a SEED=0 copy checks seed fix-up.
module tb_pattern_source_gen;

  logic        clk = 1'b0;
  logic        rst, en, mode_load, out_ready;
  logic [1:0]  mode_in;

  logic        out_valid, holding;
  logic [23:0] result;
  logic [1:0]  mode_q;

  logic        w4_valid, w4_holding;
  logic [3:0]  w4_result;
  logic [1:0]  w4_mode;

  logic        s0_valid, s0_holding;
  logic [23:0] s0_result;
  logic [1:0]  s0_mode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pattern_source_gen dut (
    .clk(clk), .rst(rst), .en(en), .mode_in(mode_in), .mode_load(mode_load),
    .out_ready(out_ready), .out_valid(out_valid), .result(result),
    .mode_q(mode_q), .holding(holding)
  );

  pattern_source_gen #(.WIDTH(4), .CONST_VAL(4'hE), .SEED(4'h1),
                       .LFSR_TAPS(4'hC), .HOLD_CYCLES(4)) dut_w4 (
    .clk(clk), .rst(rst), .en(en), .mode_in(mode_in), .mode_load(mode_load),
    .out_ready(out_ready), .out_valid(w4_valid), .result(w4_result),
    .mode_q(w4_mode), .holding(w4_holding)
  );

  pattern_source_gen #(.SEED(24'h0)) dut_s0 (
    .clk(clk), .rst(rst), .en(en), .mode_in(mode_in), .mode_load(mode_load),
    .out_ready(out_ready), .out_valid(s0_valid), .result(s0_result),
    .mode_q(s0_mode), .holding(s0_holding)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are looked at 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] m);
    mode_in   = m;
    mode_load = 1'b1;
    tick();
    mode_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; out_ready = 1'b1; mode_load = 1'b0; mode_in = 2'd0;
    repeat (3) tick();
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_holding", 32'(holding), 32'h1);
    chk("rst_mode", 32'(mode_q), 32'h0);

    // Hold-off: three more edges still holding, the fourth enters RUN.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_holding", 32'(holding), 32'h1);
      chk("hold_valid", 32'(out_valid), 32'h0);
      chk("hold_result", 32'(result), 32'h0);
    end
    tick();
    chk("run_holding", 32'(holding), 32'h0);
    chk("run_valid", 32'(out_valid), 32'h1);
    chk("run_const", 32'(result), 32'hC0FFEE);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("const_xfer", 32'(result), 32'hC0FFEE);
    end

    // COUNT with backpressure: load, then ready 1,0,0,1,1.
    load(2'd1);
    chk("cnt_mode", 32'(mode_q), 32'h1);
    chk("cnt_first", 32'(result), 32'h0);
    begin
      logic        rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [23:0] exp [5] = '{24'd1, 24'd1, 24'd1, 24'd2, 24'd3};
      for (int i = 0; i < 5; i++) begin
        out_ready = rdy[i];
        tick();
        chk("cnt_bp", 32'(result), 32'(exp[i]));
        chk("cnt_bp_valid", 32'(out_valid), 32'h1);
      end
    end
    // WIDTH=4 copy has seen the same 3 transfers; 13 more wrap F -> 0.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("w4_top", 32'(w4_result), 32'hF);
    tick();
    chk("w4_wrap", 32'(w4_result), 32'h0);
    chk("cnt_16", 32'(result), 32'h10);

    // LFSR sequence; SEED=0 copy must start at 1.
    load(2'd2);
    chk("lfsr_0", 32'(result), 32'h000001);
    chk("s0_seed", 32'(s0_result), 32'h000001);
    tick(); chk("lfsr_1", 32'(result), 32'hE10000);
    tick(); chk("lfsr_2", 32'(result), 32'h708000);
    tick(); chk("lfsr_3", 32'(result), 32'h384000);

    // Load collides with a transfer: the load wins.
    load(2'd1);
    chk("coll_result", 32'(result), 32'h0);
    chk("coll_mode", 32'(mode_q), 32'h1);

    // Drop en for 3 cycles: valid falls one edge later, word frozen.
    out_ready = 1'b0;
    en = 1'b0;
    tick();
    chk("en0_valid", 32'(out_valid), 32'h0);
    chk("en0_result", 32'(result), 32'h0);
    out_ready = 1'b1;
    repeat (2) begin
      tick();
      chk("en0_valid_hold", 32'(out_valid), 32'h0);
      chk("en0_frozen", 32'(result), 32'h0);
    end
    en = 1'b1;
    tick();
    chk("en1_valid", 32'(out_valid), 32'h1);
    chk("en1_result", 32'(result), 32'h0);
    tick();
    chk("en1_resume", 32'(result), 32'h1);

    // WALK: 1,2,4,...,800000 then back to 1.
    load(2'd3);
    chk("walk_0", 32'(result), 32'h1);
    for (int i = 1; i < 24; i++) begin
      tick();
      chk("walk", 32'(result), 32'h1 << i);
    end
    tick();
    chk("walk_wrap", 32'(result), 32'h1);

    // Reset mid-run at COUNT value 5.
    load(2'd1);
    repeat (5) tick();
    chk("mid_cnt5", 32'(result), 32'h5);
    rst = 1'b1;
    tick();
    chk("mid_rst_result", 32'(result), 32'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_mode", 32'(mode_q), 32'h0);
    chk("mid_rst_holding", 32'(holding), 32'h1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rehold_holding", 32'(holding), 32'h1);
      chk("rehold_valid", 32'(out_valid), 32'h0);
    end
    tick();
    chk("rerun_valid", 32'(out_valid), 32'h1);
    chk("rerun_const", 32'(result), 32'hC0FFEE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
